// File: rtl/psx_pad_emulator_pkg.sv
// Shared constants, FSM encoding and helpers for the PSX pad emulator.
package psx_pad_emulator_pkg;

   localparam logic [7:0] CMD_START = 8'h01;
   localparam logic [7:0] CMD_POLL  = 8'h42;
   localparam logic [7:0] READY     = 8'h5A;
   localparam logic [7:0] IDLE_HI   = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHIFT     = 3'd1,
      ST_ACK_WAIT  = 3'd2,
      ST_ACK_PULSE = 3'd3,
      ST_IGNORE    = 3'd4
   } state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/psx_pad_emulator_if.sv
// PSX bus between console (master) and pad (slave).
// Console clocks a byte LSB first on psx_clk (idle high) while att is low; the pad
// answers on data while data_oe is set and pulses ack low to ask for the next byte.
interface psx_pad_emulator_if;
   logic psx_clk;
   logic cmd;
   logic att;
   logic data;
   logic data_oe;
   logic ack;

   modport master (output psx_clk, output cmd, output att,
                   input data, input data_oe, input ack);
   modport slave  (input psx_clk, input cmd, input att,
                   output data, output data_oe, output ack);
endinterface

// File: rtl/psx_pad_emulator_edge_sync.sv
// Multi-flop synchroniser for an asynchronous line plus single-cycle rise/fall pulses.
module psx_pad_emulator_edge_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/psx_pad_emulator.sv
// PSX controller emulator: answers the 0x01/0x42 poll with a digital or analog frame,
// driving DATA and ACK from a snapshot of the user-side button/stick state.
module psx_pad_emulator
   import psx_pad_emulator_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ACK_DELAY   = 40,
   parameter int unsigned ACK_WIDTH   = 8,
   parameter bit          ANALOG_EN   = 1'b1,
   parameter logic [7:0]  DIGITAL_ID  = 8'h41,
   parameter logic [7:0]  ANALOG_ID   = 8'h73
) (
   input  logic                clk,
   input  logic                rst_n,
   psx_pad_emulator_if.slave   bus,
   input  logic [15:0]         buttons_n,
   input  logic [31:0]         sticks,
   input  logic                analog_mode,
   output logic                busy,
   output logic                frame_done,
   output state_e              dbg_state
);

   localparam int unsigned    ACK_CW    = $clog2(max2(ACK_DELAY, ACK_WIDTH) + 1);
   localparam logic [ACK_CW-1:0] DELAY_END = ACK_CW'(ACK_DELAY - 1);
   localparam logic [ACK_CW-1:0] WIDTH_END = ACK_CW'(ACK_WIDTH - 1);

   state_e state_q, state_d;
   logic [15:0] btn_q, btn_d;
   logic [31:0] stk_q, stk_d;
   logic        mode_q, mode_d;
   logic [7:0]  rx_q, rx_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [3:0]  byte_idx_q, byte_idx_d;
   logic [ACK_CW-1:0] ack_cnt_q, ack_cnt_d;
   logic data_q, data_d, data_oe_q, data_oe_d, ack_q, ack_d;
   logic busy_q, busy_d, frame_done_q, frame_done_d;
   logic [SYNC_STAGES-1:0] cmd_sync_q, cmd_sync_d;

   logic clk_s, clk_rise, clk_fall, att_s, att_rise, att_fall, cmd_s;
   logic [3:0] last_idx, byte_nxt;
   logic [7:0] rx_full, tx_cur, tx_nxt;
   logic byte_end, reject, is_last;

   psx_pad_emulator_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
      .clk(clk), .rst_n(rst_n), .d(bus.psx_clk), .q(clk_s), .rise(clk_rise), .fall(clk_fall));

   // att resets to "selected" so a reset released mid-frame parks in IGNORE instead of joining.
   psx_pad_emulator_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_att_sync (
      .clk(clk), .rst_n(rst_n), .d(bus.att), .q(att_s), .rise(att_rise), .fall(att_fall));

   // cmd is sampled only on psx_clk rises, so it needs no edge pulses.
   always_comb cmd_sync_d = {cmd_sync_q[SYNC_STAGES-2:0], bus.cmd};
   assign cmd_s = cmd_sync_q[SYNC_STAGES-1];

   function automatic logic [7:0] tx_of(input logic [3:0] idx, input logic m,
                                        input logic [15:0] b, input logic [31:0] s);
      unique case (idx)
         4'd0:    return IDLE_HI;
         4'd1:    return m ? ANALOG_ID : DIGITAL_ID;
         4'd2:    return READY;
         4'd3:    return b[7:0];
         4'd4:    return b[15:8];
         4'd5:    return s[7:0];
         4'd6:    return s[15:8];
         4'd7:    return s[23:16];
         4'd8:    return s[31:24];
         default: return IDLE_HI;
      endcase
   endfunction

   always_comb begin
      last_idx = mode_q ? 4'd8 : 4'd4;
      is_last  = (byte_idx_q == last_idx);
      byte_nxt = is_last ? byte_idx_q : byte_idx_q + 4'd1;
      tx_cur   = tx_of(byte_idx_q, mode_q, btn_q, stk_q);
      tx_nxt   = tx_of(byte_nxt, mode_q, btn_q, stk_q);
      rx_full  = {cmd_s, rx_q[7:1]};
      byte_end = clk_rise && (bit_idx_q == 3'd7);
      reject   = ((byte_idx_q == 4'd0) && (rx_full != CMD_START)) ||
                 ((byte_idx_q == 4'd1) && (rx_full != CMD_POLL));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (att_fall) state_d = ST_SHIFT;
                       else if (!att_s) state_d = ST_IGNORE;
         ST_SHIFT:     if (byte_end) state_d = (reject || is_last) ? ST_IGNORE : ST_ACK_WAIT;
         ST_ACK_WAIT:  if (clk_fall) state_d = ST_SHIFT;
                       else if (ack_cnt_q == DELAY_END) state_d = ST_ACK_PULSE;
         ST_ACK_PULSE: if (clk_fall || ack_cnt_q == WIDTH_END) state_d = ST_SHIFT;
         ST_IGNORE:    state_d = ST_IGNORE;
         default:      state_d = ST_IDLE;
      endcase
      if (att_rise) state_d = ST_IDLE;
   end

   always_comb begin
      data_d = data_q;   data_oe_d = data_oe_q;   ack_d = ack_q;
      busy_d = busy_q;   frame_done_d = 1'b0;     rx_d = rx_q;
      bit_idx_d = bit_idx_q;   byte_idx_d = byte_idx_q;   ack_cnt_d = ack_cnt_q;
      btn_d = btn_q;     stk_d = stk_q;           mode_d = mode_q;
      unique case (state_q)
         ST_IDLE: if (att_fall) begin
            btn_d = buttons_n;  stk_d = sticks;  mode_d = analog_mode & ANALOG_EN;
            busy_d = 1'b1;      byte_idx_d = 4'd0;  bit_idx_d = 3'd0;
         end
         ST_SHIFT: begin
            if (clk_fall) begin
               data_oe_d = 1'b1;
               data_d    = tx_cur[bit_idx_q];
            end
            if (clk_rise) begin
               rx_d      = rx_full;
               bit_idx_d = bit_idx_q + 3'd1;
               ack_cnt_d = '0;
            end
            if (byte_end && (reject || is_last)) begin
               data_oe_d = 1'b0;
               data_d    = 1'b1;
            end
            if (byte_end && !reject && is_last) begin
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
            end
         end
         ST_ACK_WAIT, ST_ACK_PULSE: begin
            // A console clock edge inside the gap wins: that fall already carries bit0.
            if (clk_fall) begin
               ack_d      = 1'b1;
               byte_idx_d = byte_nxt;
               data_oe_d  = 1'b1;
               data_d     = tx_nxt[0];
            end else if (state_q == ST_ACK_WAIT) begin
               if (ack_cnt_q == DELAY_END) begin
                  ack_d     = 1'b0;
                  ack_cnt_d = '0;
               end else ack_cnt_d = ack_cnt_q + ACK_CW'(1);
            end else begin
               if (ack_cnt_q == WIDTH_END) begin
                  ack_d      = 1'b1;
                  byte_idx_d = byte_nxt;
               end else ack_cnt_d = ack_cnt_q + ACK_CW'(1);
            end
         end
         ST_IGNORE: begin
            data_oe_d = 1'b0;  data_d = 1'b1;  ack_d = 1'b1;
         end
         default: ;
      endcase
      if (att_rise) begin
         data_oe_d = 1'b0;  data_d = 1'b1;  ack_d = 1'b1;
         busy_d = 1'b0;     frame_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q <= '1;  stk_q <= '0;  mode_q <= 1'b0;  rx_q <= '0;
         bit_idx_q <= '0;  byte_idx_q <= '0;  ack_cnt_q <= '0;
         data_q <= 1'b1;  data_oe_q <= 1'b0;  ack_q <= 1'b1;
         busy_q <= 1'b0;  frame_done_q <= 1'b0;  cmd_sync_q <= '1;
      end else begin
         btn_q <= btn_d;  stk_q <= stk_d;  mode_q <= mode_d;  rx_q <= rx_d;
         bit_idx_q <= bit_idx_d;  byte_idx_q <= byte_idx_d;  ack_cnt_q <= ack_cnt_d;
         data_q <= data_d;  data_oe_q <= data_oe_d;  ack_q <= ack_d;
         busy_q <= busy_d;  frame_done_q <= frame_done_d;  cmd_sync_q <= cmd_sync_d;
      end
   end

   assign bus.data    = data_q;
   assign bus.data_oe = data_oe_q;
   assign bus.ack     = ack_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_psx_pad_emulator.sv
// Console-side bench: polls an analog-capable pad and a digital-only pad in parallel
// and compares every response byte, ACK count and frame_done count against a frame model.
module tb_psx_pad_emulator;
   import psx_pad_emulator_pkg::*;

   localparam int SYNC = 2;
   localparam int ADLY = 40;
   localparam int AWID = 24;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   psx_pad_emulator_if bus ();
   psx_pad_emulator_if bus_d ();
   assign bus_d.psx_clk = bus.psx_clk;
   assign bus_d.cmd     = bus.cmd;
   assign bus_d.att     = bus.att;

   logic [15:0] buttons_n;
   logic [31:0] sticks;
   logic        analog_mode;
   logic        busy_a, fd_a, busy_d, fd_d;
   state_e      st_a, st_d;

   psx_pad_emulator #(.SYNC_STAGES(SYNC), .ACK_DELAY(ADLY), .ACK_WIDTH(AWID), .ANALOG_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus), .buttons_n(buttons_n), .sticks(sticks),
      .analog_mode(analog_mode), .busy(busy_a), .frame_done(fd_a), .dbg_state(st_a));

   psx_pad_emulator #(.SYNC_STAGES(SYNC), .ACK_DELAY(ADLY), .ACK_WIDTH(AWID), .ANALOG_EN(1'b0)) dut_d (
      .clk(clk), .rst_n(rst_n), .bus(bus_d), .buttons_n(buttons_n), .sticks(sticks),
      .analog_mode(analog_mode), .busy(busy_d), .frame_done(fd_d), .dbg_state(st_d));

   int n_cmp = 0;
   int n_bad = 0;
   int ack_cnt_a = 0, ack_cnt_d = 0, done_cnt_a = 0, done_cnt_d = 0;
   logic ack_prev_a = 1'b1, ack_prev_d = 1'b1;
   logic [7:0] cb [9];

   always @(negedge clk) begin
      ack_prev_a <= bus.ack;
      ack_prev_d <= bus_d.ack;
      if (ack_prev_a && !bus.ack) ack_cnt_a <= ack_cnt_a + 1;
      if (ack_prev_d && !bus_d.ack) ack_cnt_d <= ack_cnt_d + 1;
      if (fd_a) done_cnt_a <= done_cnt_a + 1;
      if (fd_d) done_cnt_d <= done_cnt_d + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] c, input int nbits,
                            output logic [7:0] ra, output logic [7:0] rd,
                            output bit oa_all, output bit od_all,
                            output bit oa_any, output bit od_any, output logic ack0);
      ra = '1; rd = '1; oa_all = 1; od_all = 1; oa_any = 0; od_any = 0; ack0 = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.psx_clk = 1'b0;
         bus.cmd     = c[i];
         repeat (HALF - 1) @(negedge clk);
         ra[i] = bus.data;
         rd[i] = bus_d.data;
         oa_all = oa_all & bus.data_oe;    od_all = od_all & bus_d.data_oe;
         oa_any = oa_any | bus.data_oe;    od_any = od_any | bus_d.data_oe;
         if (i == 0) ack0 = bus.ack;
         @(negedge clk);
         bus.psx_clk = 1'b1;
         repeat (HALF - 1) @(negedge clk);
      end
   endtask

   task automatic wait_ack(input string tag, input bit early);
      int t;
      t = 0;
      while (bus.ack !== 1'b0 && t < 200) begin @(negedge clk); t++; end
      check({tag, "_ack_low"}, bus.ack, 1'b0);
      if (early) repeat (10) @(negedge clk);
      else begin
         t = 0;
         while (bus.ack !== 1'b1 && t < 100) begin @(negedge clk); t++; end
         check({tag, "_ack_high"}, bus.ack, 1'b1);
         repeat (4) @(negedge clk);
      end
   endtask

   // rst_k >= 0 pulses reset before byte rst_k while att stays low.
   task automatic run_frame(input string tag, input int n, input int early_k,
                            input int chg_k, input int rst_k);
      logic [7:0] resp [2][9];
      int stop [2], last [2], exp_acks [2], exp_done [2], acks0 [2], done0 [2];
      bit mode [2];
      bit live, prev_early;
      logic [7:0] rx [2];
      bit oe_all [2], oe_any [2];
      logic ack0;
      mode[0] = analog_mode;
      mode[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         resp[d] = '{8'hFF, (mode[d] ? 8'h73 : 8'h41), 8'h5A, buttons_n[7:0], buttons_n[15:8],
                     sticks[7:0], sticks[15:8], sticks[23:16], sticks[31:24]};
         last[d] = mode[d] ? 8 : 4;
         if (cb[0] != 8'h01)      stop[d] = 0;
         else if (cb[1] != 8'h42) stop[d] = 1;
         else                     stop[d] = last[d];
         if (rst_k >= 0) exp_acks[d] = (rst_k < stop[d]) ? rst_k : stop[d];
         else            exp_acks[d] = (n < stop[d]) ? n : stop[d];
         exp_done[d] = (rst_k < 0 && n > stop[d] && stop[d] == last[d]) ? 1 : 0;
      end
      acks0[0] = ack_cnt_a;  acks0[1] = ack_cnt_d;
      done0[0] = done_cnt_a; done0[1] = done_cnt_d;
      live = 1; prev_early = 0;
      @(negedge clk);
      bus.att = 1'b0;
      repeat (6) @(negedge clk);
      for (int k = 0; k < n; k++) begin
         if (k == rst_k) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            check({tag, "_rst_data"}, bus.data, 1'b1);
            check({tag, "_rst_oe"}, bus.data_oe, 1'b0);
            check({tag, "_rst_ack"}, bus.ack, 1'b1);
            check({tag, "_rst_busy"}, busy_a, 1'b0);
            check({tag, "_rst_done"}, fd_a, 1'b0);
            rst_n = 1'b1;
            live = 0;
            repeat (8) @(negedge clk);
         end
         send_byte(cb[k], 8, rx[0], rx[1], oe_all[0], oe_all[1], oe_any[0], oe_any[1], ack0);
         if (prev_early) check($sformatf("%s_b%0d_ack_cut", tag, k), ack0, 1'b1);
         prev_early = 0;
         for (int d = 0; d < 2; d++) begin
            if (live && k <= stop[d]) begin
               check($sformatf("%s_p%0d_b%0d_data", tag, d, k), rx[d], resp[d][k]);
               check($sformatf("%s_p%0d_b%0d_oe", tag, d, k), oe_all[d], 1'b1);
            end else
               check($sformatf("%s_p%0d_b%0d_released", tag, d, k), oe_any[d], 1'b0);
         end
         if (k == chg_k) begin
            buttons_n = 16'($urandom);
            sticks = $urandom;
            analog_mode = ~analog_mode;
         end
         if (live && k < stop[0] && k < n - 1) begin
            wait_ack($sformatf("%s_b%0d", tag, k), k == early_k);
            prev_early = (k == early_k);
         end else repeat (80) @(negedge clk);
      end
      @(negedge clk);
      bus.att = 1'b1;
      repeat (8) @(negedge clk);
      check({tag, "_acks_a"}, ack_cnt_a - acks0[0], exp_acks[0]);
      check({tag, "_acks_d"}, ack_cnt_d - acks0[1], exp_acks[1]);
      check({tag, "_done_a"}, done_cnt_a - done0[0], exp_done[0]);
      check({tag, "_done_d"}, done_cnt_d - done0[1], exp_done[1]);
      check({tag, "_end_busy"}, busy_a, 1'b0);
      check({tag, "_end_oe"}, bus.data_oe, 1'b0);
   endtask

   task automatic run_abort();
      logic [7:0] ra, rd;
      bit oa, od, oaa, oda;
      logic ack0;
      int a0, d0;
      a0 = ack_cnt_a; d0 = done_cnt_a;
      @(negedge clk);
      bus.att = 1'b0;
      repeat (6) @(negedge clk);
      send_byte(8'h01, 8, ra, rd, oa, od, oaa, oda, ack0);
      wait_ack("abort_b0", 0);
      send_byte(8'h42, 8, ra, rd, oa, od, oaa, oda, ack0);
      wait_ack("abort_b1", 0);
      send_byte(8'h00, 4, ra, rd, oa, od, oaa, oda, ack0);
      check("abort_partial_oe", oa, 1'b1);
      check("abort_partial_bits", ra[3:0], 4'hA);
      @(negedge clk);
      bus.att = 1'b1;
      repeat (SYNC + 2) @(negedge clk);
      check("abort_oe", bus.data_oe, 1'b0);
      check("abort_ack", bus.ack, 1'b1);
      check("abort_busy", busy_a, 1'b0);
      check("abort_busy_d", busy_d, 1'b0);
      repeat (8) @(negedge clk);
      check("abort_acks", ack_cnt_a - a0, 2);
      check("abort_no_done", done_cnt_a - d0, 0);
   endtask

   initial begin
      bus.psx_clk = 1'b1; bus.cmd = 1'b1; bus.att = 1'b1;
      buttons_n = '1; sticks = '0; analog_mode = 1'b0;
      cb = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      repeat (3) @(negedge clk);
      check("reset_data", bus.data, 1'b1);
      check("reset_oe", bus.data_oe, 1'b0);
      check("reset_ack", bus.ack, 1'b1);
      check("reset_busy", busy_a, 1'b0);
      check("reset_done", fd_a, 1'b0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_busy", busy_a, 1'b0);

      buttons_n = 16'hFFFE;
      run_frame("digital", 5, -1, -1, -1);

      analog_mode = 1'b1;
      sticks = 32'h807F10F0;
      buttons_n = 16'($urandom);
      run_frame("analog", 9, -1, -1, -1);

      cb[0] = 8'h81;
      run_frame("bad_addr", 5, -1, -1, -1);
      cb[0] = 8'h01;

      run_abort();
      buttons_n = 16'($urandom);
      run_frame("post_abort", 9, -1, -1, -1);

      analog_mode = 1'b1;
      run_frame("early_snap", 9, 2, 1, -1);

      run_frame("rst_mid", 9, -1, -1, 3);
      run_frame("post_rst", 9, -1, -1, -1);

      for (int r = 0; r < 6; r++) begin
         buttons_n   = 16'($urandom);
         sticks      = $urandom;
         analog_mode = 1'($urandom_range(0, 1));
         for (int i = 2; i < 9; i++) cb[i] = 8'($urandom);
         cb[1] = ($urandom_range(0, 5) == 0) ? 8'h43 : 8'h42;
         run_frame($sformatf("rand%0d", r), 9,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, -1, -1);
      end
      cb[1] = 8'h42;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
